// File: rtl/regfile_sb_if.sv
// Register-file bus: two read ports, one write port, one reserve port and scoreboard status.
// The master drives selectors and strobes; the slave returns read data and busy state.
interface regfile_sb_if #(
  parameter int NREGS = 8,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(NREGS + 1)
);
  logic [SELW-1:0]  rd_a_sel;
  logic [SELW-1:0]  rd_b_sel;
  logic [WIDTH-1:0] rd_a_data;
  logic [WIDTH-1:0] rd_b_data;
  logic             rd_a_busy;
  logic             rd_b_busy;
  logic             wr_en;
  logic [SELW-1:0]  wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             res_en;
  logic [SELW-1:0]  res_sel;
  logic             wr_unres;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, res_en, res_sel,
    input  rd_a_data, rd_b_data, rd_a_busy, rd_b_busy, wr_unres, busy_vec
  );

  modport slave (
    input  rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, res_en, res_sel,
    output rd_a_data, rd_b_data, rd_a_busy, rd_b_busy, wr_unres, busy_vec
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with per-register pending-write scoreboard.
// Selector code k addresses r(k-1); code 0 and codes above NREGS are NONE.
module regfile_sb #(
  parameter int NREGS = 8,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(NREGS + 1)
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] res_hit;
  logic             unres;
  logic             unres_hit;
  logic [WIDTH-1:0] a_data_next;
  logic [WIDTH-1:0] b_data_next;
  logic             a_busy_next;
  logic             b_busy_next;

  // One-hot decode: NONE codes simply match no register.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      wr_hit[i]  = bus.wr_en  && (bus.wr_sel  == SELW'(i + 1));
      res_hit[i] = bus.res_en && (bus.res_sel == SELW'(i + 1));
    end
  end

  // Reserve is applied after the write clear so it wins on a same-register collision.
  assign busy_next = (busy & ~wr_hit) | res_hit;
  assign unres_hit = |(wr_hit & ~busy);

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    a_data_next = '0;
    a_busy_next = 1'b0;
    b_data_next = '0;
    b_busy_next = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.rd_a_sel == SELW'(i + 1)) begin
        a_data_next = wr_hit[i] ? bus.wr_data : regs[i];
        a_busy_next = busy_next[i];
      end
      if (bus.rd_b_sel == SELW'(i + 1)) begin
        b_data_next = wr_hit[i] ? bus.wr_data : regs[i];
        b_busy_next = busy_next[i];
      end
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is plain flops that must read back zero after reset, so it is reset too.
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy          <= '0;
      unres         <= 1'b0;
      bus.rd_a_data <= '0;
      bus.rd_b_data <= '0;
      bus.rd_a_busy <= 1'b0;
      bus.rd_b_busy <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= bus.wr_data;
        end
      end
      busy <= busy_next;
      if (unres_hit) begin
        unres <= 1'b1;
      end
      bus.rd_a_data <= a_data_next;
      bus.rd_b_data <= b_data_next;
      bus.rd_a_busy <= a_busy_next;
      bus.rd_b_busy <= b_busy_next;
    end
  end

  assign bus.busy_vec = busy;
  assign bus.wr_unres = unres;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb at 8x8 and 16x32: a behavioural model pushes expected
// outputs into a scoreboard as each cycle is driven; they are popped and checked after the edge.
module tb_regfile_sb;

  typedef enum logic [2:0] {K_RA_DATA, K_RA_BUSY, K_RB_DATA, K_RB_BUSY, K_UNRES, K_BVEC} kind_e;
  typedef struct {
    string       tag;
    int          dut;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.NREGS(8),  .WIDTH(8))  bus8  ();
  regfile_sb_if #(.NREGS(16), .WIDTH(32)) bus16 ();

  regfile_sb #(.NREGS(8),  .WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  regfile_sb #(.NREGS(16), .WIDTH(32)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  exp_t        sb [$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_reg   [2][16];
  logic [15:0] m_busy  [2];
  logic        m_unres [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int d, input kind_e k);
    logic [31:0] v;
    v = '0;
    if (d == 0) begin
      case (k)
        K_RA_DATA: v = 32'(bus8.rd_a_data);
        K_RA_BUSY: v = 32'(bus8.rd_a_busy);
        K_RB_DATA: v = 32'(bus8.rd_b_data);
        K_RB_BUSY: v = 32'(bus8.rd_b_busy);
        K_UNRES:   v = 32'(bus8.wr_unres);
        default:   v = 32'(bus8.busy_vec);
      endcase
    end else begin
      case (k)
        K_RA_DATA: v = bus16.rd_a_data;
        K_RA_BUSY: v = 32'(bus16.rd_a_busy);
        K_RB_DATA: v = bus16.rd_b_data;
        K_RB_BUSY: v = 32'(bus16.rd_b_busy);
        K_UNRES:   v = 32'(bus16.wr_unres);
        default:   v = 32'(bus16.busy_vec);
      endcase
    end
    return v;
  endfunction

  function automatic void push(input string name, input string field, input int d,
                               input kind_e k, input logic [31:0] e);
    exp_t item;
    item.tag  = $sformatf("%s.%s", name, field);
    item.dut  = d;
    item.kind = k;
    item.exp  = e;
    sb.push_back(item);
  endfunction

  // One clock cycle on DUT d (the other DUT sees idle strobes; rst is shared).
  task automatic step(input string name, input int d, input bit r,
                      input bit we, input int ws, input logic [31:0] wd,
                      input bit re, input int rs, input int ra, input int rb);
    int          n;
    logic [31:0] mask;
    logic [15:0] pb;
    logic [15:0] nb;
    bit          wv;
    bit          rv;
    logic [31:0] ea, eb;
    logic        ba, bb, eu;
    exp_t        item;

    rst            = r;
    bus8.wr_en     = (d == 0) && we;
    bus8.wr_sel    = 4'(ws);
    bus8.wr_data   = 8'(wd);
    bus8.res_en    = (d == 0) && re;
    bus8.res_sel   = 4'(rs);
    bus8.rd_a_sel  = 4'(ra);
    bus8.rd_b_sel  = 4'(rb);
    bus16.wr_en    = (d == 1) && we;
    bus16.wr_sel   = 5'(ws);
    bus16.wr_data  = wd;
    bus16.res_en   = (d == 1) && re;
    bus16.res_sel  = 5'(rs);
    bus16.rd_a_sel = 5'(ra);
    bus16.rd_b_sel = 5'(rb);

    n    = (d == 1) ? 16 : 8;
    mask = (d == 1) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    pb   = m_busy[d];
    nb   = pb;
    wv   = we && (ws >= 1) && (ws <= n);
    rv   = re && (rs >= 1) && (rs <= n);
    if (wv) nb[ws-1] = 1'b0;
    if (rv) nb[rs-1] = 1'b1;

    ea = '0; ba = 1'b0; eb = '0; bb = 1'b0;
    eu = m_unres[d];
    if (wv && !pb[ws-1]) eu = 1'b1;
    if (ra >= 1 && ra <= n) begin
      ea = (wv && ws == ra) ? (wd & mask) : m_reg[d][ra-1];
      ba = nb[ra-1];
    end
    if (rb >= 1 && rb <= n) begin
      eb = (wv && ws == rb) ? (wd & mask) : m_reg[d][rb-1];
      bb = nb[rb-1];
    end

    if (r) begin
      ea = '0; ba = 1'b0; eb = '0; bb = 1'b0; eu = 1'b0; nb = '0;
      for (int k = 0; k < 2; k++) begin
        m_busy[k]  = '0;
        m_unres[k] = 1'b0;
        for (int j = 0; j < 16; j++) m_reg[k][j] = '0;
      end
    end else begin
      if (wv) m_reg[d][ws-1] = wd & mask;
      m_busy[d]  = nb;
      m_unres[d] = eu;
    end

    push(name, "ra_data", d, K_RA_DATA, ea);
    push(name, "ra_busy", d, K_RA_BUSY, 32'(ba));
    push(name, "rb_data", d, K_RB_DATA, eb);
    push(name, "rb_busy", d, K_RB_BUSY, 32'(bb));
    push(name, "wr_unres", d, K_UNRES, 32'(eu));
    push(name, "busy_vec", d, K_BVEC, 32'(nb));

    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      item = sb.pop_front();
      check(item.tag, observe(item.dut, item.kind), item.exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k]  = '0;
      m_unres[k] = 1'b0;
      for (int j = 0; j < 16; j++) m_reg[k][j] = '0;
    end

    // Reset, then sweep every 4-bit code on both ports of the 8x8 instance.
    step("rst", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_busy_vec16", 32'(bus16.busy_vec), 32'h0);
    for (int c = 0; c < 16; c++) begin
      step($sformatf("rst_rd%0d", c), 0, 0, 0, 0, 0, 0, 0, c, 15 - c);
    end

    // Reserve r4 and see it through the busy bypass, then release it by writeback.
    step("res5", 0, 0, 0, 0, 0, 1, 5, 5, 0);
    check("res5_busy_direct", 32'(bus8.rd_a_busy), 32'h1);
    check("res5_bvec_direct", 32'(bus8.busy_vec), 32'h10);
    step("gap", 0, 0, 0, 0, 0, 0, 0, 5, 0);
    step("wr5", 0, 0, 1, 5, 32'h3C, 0, 0, 5, 0);
    check("wr5_data_direct", 32'(bus8.rd_a_data), 32'h3C);
    check("wr5_busy_direct", 32'(bus8.rd_a_busy), 32'h0);
    check("wr5_unres_direct", 32'(bus8.wr_unres), 32'h0);

    // Reserved write to r2, then dual read of the same register and NONE reads.
    step("res3", 0, 0, 0, 0, 0, 1, 3, 0, 0);
    step("wr3", 0, 0, 1, 3, 32'hA5, 0, 0, 0, 0);
    step("rd3", 0, 0, 0, 0, 0, 0, 0, 3, 3);
    check("rd3_a_direct", 32'(bus8.rd_a_data), 32'hA5);
    check("rd3_b_direct", 32'(bus8.rd_b_data), 32'hA5);
    step("rd_none_0_9", 0, 0, 0, 0, 0, 0, 0, 0, 9);
    step("rd_none_15", 0, 0, 0, 0, 0, 0, 0, 15, 3);

    // Unreserved write sets the sticky flag, which survives legal traffic.
    step("wr2_unres", 0, 0, 1, 2, 32'h11, 0, 0, 2, 0);
    check("wr2_unres_direct", 32'(bus8.wr_unres), 32'h1);
    step("res4", 0, 0, 0, 0, 0, 1, 4, 4, 2);
    step("wr4", 0, 0, 1, 4, 32'h44, 0, 0, 4, 2);
    check("unres_sticky_direct", 32'(bus8.wr_unres), 32'h1);

    // Same-register reserve+write: data lands, reserve wins on busy.
    step("rw7", 0, 0, 1, 7, 32'h77, 1, 7, 7, 0);
    check("rw7_data_direct", 32'(bus8.rd_a_data), 32'h77);
    check("rw7_bit6_direct", 32'(bus8.busy_vec[6]), 32'h1);
    step("res8", 0, 0, 0, 0, 0, 1, 8, 8, 7);
    step("res1_wr8", 0, 0, 1, 8, 32'h88, 1, 1, 1, 8);
    check("res1_bit0_direct", 32'(bus8.busy_vec[0]), 32'h1);
    check("wr8_bit7_direct", 32'(bus8.busy_vec[7]), 32'h0);

    // Reset with strobes active drops them and discards reservations.
    step("rst_mid", 0, 1, 1, 3, 32'hFF, 1, 2, 3, 2);
    check("rst_mid_bvec_direct", 32'(bus8.busy_vec), 32'h0);
    step("rd_after_rst", 0, 0, 0, 0, 0, 0, 0, 3, 7);

    // Writes and reserves to NONE codes have no effect.
    step("none_wr0", 0, 0, 1, 0, 32'h5A, 1, 0, 0, 0);
    step("none_wr9", 0, 0, 1, 9, 32'h5A, 1, 12, 9, 12);
    check("none_unres_direct", 32'(bus8.wr_unres), 32'h0);

    // 16x32 instance: top register, NONE codes 17 and 31.
    step("w16_res", 1, 0, 0, 0, 0, 1, 16, 16, 0);
    check("w16_bvec_direct", 32'(bus16.busy_vec), 32'h8000);
    step("w16_wr", 1, 0, 1, 16, 32'hDEADBEEF, 0, 0, 16, 17);
    check("w16_data_direct", bus16.rd_a_data, 32'hDEADBEEF);
    step("w16_rd", 1, 0, 0, 0, 0, 0, 0, 16, 31);
    step("w16_none", 1, 0, 1, 17, 32'h12345678, 1, 31, 17, 31);
    check("w16_none_unres_direct", 32'(bus16.wr_unres), 32'h0);
    step("w16_unres", 1, 0, 1, 1, 32'hCAFEF00D, 0, 0, 1, 16);
    step("w16_rd1", 1, 0, 0, 0, 0, 0, 0, 1, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a pending-write scoreboard for the CPU datapath. Generalises the fixed eight-entry `NONE, r0..r7` register naming to NREGS registers of WIDTH bits, keeping selector code 0 as NONE. Provides two synchronous read ports with write-through bypass, one write port, and per-register busy bits. Decode reserves a destination; writeback releases it, so multicycle units can stall on read-after-write hazards.

## Interface
- NREGS, 8, number of registers r0..r(NREGS-1); legal 1..255
- WIDTH, 8, data width of each register
- SELW, $clog2(NREGS+1), selector width; code 0 = NONE, code k = r(k-1)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- rd_a_sel  in  SELW  read port A selector
- rd_b_sel  in  SELW  read port B selector
- rd_a_data  out  WIDTH  registered read data A
- rd_b_data  out  WIDTH  registered read data B
- rd_a_busy  out  1  registered busy flag for rd_a_sel
- rd_b_busy  out  1  registered busy flag for rd_b_sel
- wr_en  in  1  write strobe
- wr_sel  in  SELW  write selector
- wr_data  in  WIDTH  write data
- res_en  in  1  reserve strobe; marks a destination as pending
- res_sel  in  SELW  reserve selector
- wr_unres  out  1  sticky flag: a write hit a register that was not busy
- busy_vec  out  NREGS  current busy bits; bit i = r i

## Operation
- Selector decode: 0 or any code > NREGS is NONE.
  - Read of NONE returns data 0 and busy 0.
  - Write or reserve to NONE is ignored and has no effect on wr_unres.
- Storage: NREGS x WIDTH flops plus NREGS busy flops. No RAM inference is required.
- Write: when wr_en is high and the selector is valid, the register takes wr_data at the edge and its busy bit clears.
  - If that busy bit was 0 before the edge, wr_unres sets and stays set until rst.
- Reserve: when res_en is high and the selector is valid, the busy bit sets at the edge.
  - Reserve and write to the same register in the same cycle: data is written and busy ends at 1, because reserve wins. wr_unres still follows the pre-edge busy bit.
  - Reserve and write to different registers: both take effect.
- Read ports are independent; both may select the same register.
  - Data bypass: if wr_en is high and wr_sel equals rd_x_sel (valid), rd_x_data takes wr_data. Otherwise it takes the stored value.
  - Busy bypass: rd_x_busy takes the post-edge busy value, i.e. after this cycle's write clear and reserve set.
- busy_vec is the state register directly, with no bypass.
- Arithmetic: none. Data passes through unmodified at WIDTH bits.

## Timing
- Reset: all registers 0, all busy bits 0, and rd_a_data, rd_b_data, rd_a_busy, rd_b_busy, wr_unres, busy_vec all 0 the cycle after rst is sampled high.
- rst has priority over wr_en and res_en in the same cycle; those inputs are dropped.
- Reset mid-operation discards all pending reservations. It does not depend on earlier traffic.
- Read latency: 1 cycle. A selector presented in cycle N appears on rd_x_* after edge N.
- Write-to-read: 0 extra cycles through the bypass. A write in cycle N and a read of the same register in cycle N returns the new data after edge N.
- Reserve-to-busy: a reserve in cycle N is visible on rd_x_busy for a read issued in cycle N, and on busy_vec after edge N.
- No handshake back-pressure exists. Every strobe is accepted in the cycle it is high.

## Test plan
- Reset with NREGS=8, WIDTH=8: after one rst cycle, read all codes 0..15 -> data 0x00, busy 0, wr_unres 0, busy_vec 0x00.
- Write sel 3 (r2) = 0xA5, then read A=3, B=3 next cycle -> both 0xA5. Read sel 0, 9, 15 -> 0x00.
- Reserve sel 5 (r4) in cycle N, read A=5 in cycle N -> rd_a_busy=1 and busy_vec=0x10. Write 0x3C to sel 5 in cycle N+2 while reading sel 5 -> rd_a_data=0x3C, rd_a_busy=0, and wr_unres stays 0.
- Write sel 2 = 0x11 without a prior reserve -> wr_unres=1 after the edge; it holds through later legal traffic until rst.
- Simultaneous reserve and write to sel 7 (r6) = 0x77 -> register reads 0x77, busy bit 6 = 1. Reserve sel 1 plus write sel 8 together -> busy bit 0 set, busy bit 7 clear.
- Repeat the bypass and scoreboard checks with NREGS=16, WIDTH=32 (SELW=5): write 0xDEADBEEF to sel 16 (r15) and read back; sel 17 and sel 31 behave as NONE.
